// File: rtl/packer_pkg.sv
// Shared constants and types for the cpack channel packer.
// The optional partial-word flush is selected by the PACKER_FLUSH_EN macro in chan_packer.
package packer_pkg;
    localparam int SAMPLE_W  = 16;
    localparam int NUM_CH    = 4;
    localparam int WORD_W    = 64;
    localparam int LANES     = 4;
    localparam int TS_W      = 64;
    localparam int WIN_LANES = 7;

    typedef logic [2:0]          lane_idx_t;
    typedef logic [SAMPLE_W-1:0] sample_t;

    // Channel counts above the physical channel count saturate at four.
    function automatic lane_idx_t clamp_count(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction
endpackage

// File: rtl/chan_packer_lane_mux.sv
// Places count samples after fill already-held lanes inside a 7-lane window,
// returning the 4-lane word and the 3 lanes that spill into the next word.
module chan_packer_lane_mux
    import packer_pkg::*;
(
    input  sample_t   [LANES-1:0]  acc,
    input  logic      [1:0]        fill,
    input  lane_idx_t              count,
    input  sample_t   [NUM_CH-1:0] samples,
    output sample_t   [LANES-1:0]  word,
    output sample_t   [LANES-2:0]  carry
);
    sample_t [WIN_LANES-1:0] win;

    generate
        for (genvar gi = 0; gi < WIN_LANES; gi++) begin : g_lane
            localparam lane_idx_t LI = lane_idx_t'(gi);
            lane_idx_t off;
            assign off = LI - lane_idx_t'(fill);
            if (gi < LANES) begin : g_low
                assign win[gi] = (LI < lane_idx_t'(fill)) ? acc[gi] :
                                 (off < count)            ? samples[off[1:0]] : '0;
            end else begin : g_high
                // fill is at most 3 here, so off never reaches past channel 3
                assign win[gi] = (off < count) ? samples[off[1:0]] : '0;
            end
        end
    endgenerate

    assign word  = win[LANES-1:0];
    assign carry = win[WIN_LANES-1:LANES];
endmodule

// File: rtl/chan_packer.sv
// Packs 1-4 enabled 16-bit channels into 64-bit words tagged with first-sample timestamp and sync.
// Define PACKER_FLUSH_EN to emit the partial word when en falls; otherwise it is held across gaps.
module chan_packer
    import packer_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [TS_W-1:0]     timestamp_in,
    input  logic [2:0]          enabled_chan_count,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] data_in_0,
    input  logic [SAMPLE_W-1:0] data_in_1,
    input  logic [SAMPLE_W-1:0] data_in_2,
    input  logic [SAMPLE_W-1:0] data_in_3,
    output logic                data_out_sync,
    output logic                data_out_valid,
    output logic [WORD_W-1:0]   data_out,
    output logic [TS_W-1:0]     timestamp_out
);
    sample_t   [LANES-1:0]  acc_reg;
    logic      [1:0]        fill_reg;
    lane_idx_t              n_reg;
    logic      [TS_W-1:0]   ts_reg;
    logic                   sync_reg;

    logic      [WORD_W-1:0] data_out_reg;
    logic      [TS_W-1:0]   ts_out_reg;
    logic                   sync_out_reg;
    logic                   valid_reg;

    sample_t   [NUM_CH-1:0] samples;
    sample_t   [LANES-1:0]  word;
    sample_t   [LANES-2:0]  carry;
    lane_idx_t              n_eff;
    lane_idx_t              total;
    logic      [1:0]        fill_eff;
    logic                   accept;
    logic                   full;
    logic                   flush;
    logic      [TS_W-1:0]   first_ts;
    logic                   first_sync;

    assign samples  = {data_in_3, data_in_2, data_in_1, data_in_0};
    assign n_eff    = clamp_count(enabled_chan_count);
    assign accept   = en && (n_eff != 3'd0);
    // A new channel count abandons whatever partial word was being built.
    assign fill_eff = (n_eff != n_reg) ? 2'd0 : fill_reg;
    assign total    = lane_idx_t'(fill_eff) + n_eff;
    assign full     = total[2];

    assign first_ts   = (fill_eff == 2'd0) ? timestamp_in : ts_reg;
    assign first_sync = (fill_eff == 2'd0) ? 1'b1 : sync_reg;

    chan_packer_lane_mux u_lane_mux (
        .acc     (acc_reg),
        .fill    (fill_eff),
        .count   (n_eff),
        .samples (samples),
        .word    (word),
        .carry   (carry)
    );

`ifdef PACKER_FLUSH_EN
    logic en_prev_reg;
    assign flush = !en && en_prev_reg && (fill_reg != 2'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) en_prev_reg <= 1'b0;
        else         en_prev_reg <= en;
    end
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_reg      <= '0;
            fill_reg     <= 2'd0;
            n_reg        <= 3'd0;
            ts_reg       <= '0;
            sync_reg     <= 1'b0;
            data_out_reg <= '0;
            ts_out_reg   <= '0;
            sync_out_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (accept) begin
                n_reg    <= n_eff;
                fill_reg <= total[1:0];
                if (full) begin
                    data_out_reg <= word;
                    ts_out_reg   <= first_ts;
                    sync_out_reg <= first_sync;
                    valid_reg    <= 1'b1;
                    // Carried lanes come from this set but never start at channel 0.
                    acc_reg      <= {{SAMPLE_W{1'b0}}, carry};
                    ts_reg       <= timestamp_in;
                    sync_reg     <= 1'b0;
                end else begin
                    acc_reg  <= word;
                    ts_reg   <= first_ts;
                    sync_reg <= first_sync;
                end
            end else if (flush) begin
                data_out_reg <= acc_reg;
                ts_out_reg   <= ts_reg;
                sync_out_reg <= sync_reg;
                valid_reg    <= 1'b1;
                acc_reg      <= '0;
                fill_reg     <= 2'd0;
            end
        end
    end

    assign data_out       = data_out_reg;
    assign timestamp_out  = ts_out_reg;
    assign data_out_sync  = sync_out_reg;
    assign data_out_valid = valid_reg;
endmodule

// File: tb/tb_chan_packer.sv
// Directed bench for chan_packer: one sample set per clock, hand-computed packed words.
module tb_chan_packer;
    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] timestamp_in = 64'h100;
    logic [2:0]  enabled_chan_count;
    logic        en;
    logic [15:0] data_in_0, data_in_1, data_in_2, data_in_3;
    logic        data_out_sync;
    logic        data_out_valid;
    logic [63:0] data_out;
    logic [63:0] timestamp_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] t0, tx;

    always #5 clk = ~clk;
    always @(negedge clk) timestamp_in <= timestamp_in + 64'd1;

    chan_packer dut (
        .clk                (clk),
        .resetn             (resetn),
        .timestamp_in       (timestamp_in),
        .enabled_chan_count (enabled_chan_count),
        .en                 (en),
        .data_in_0          (data_in_0),
        .data_in_1          (data_in_1),
        .data_in_2          (data_in_2),
        .data_in_3          (data_in_3),
        .data_out_sync      (data_out_sync),
        .data_out_valid     (data_out_valid),
        .data_out           (data_out),
        .timestamp_out      (timestamp_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Drive one set (channels j+1..j+4), return the timestamp seen by the accepting edge.
    task automatic apply_set(input logic e, input logic [2:0] n, input int j,
                             output logic [63:0] ts_acc);
        en                 = e;
        enabled_chan_count = n;
        data_in_0          = 16'(j + 1);
        data_in_1          = 16'(j + 2);
        data_in_2          = 16'(j + 3);
        data_in_3          = 16'(j + 4);
        @(posedge clk);
        ts_acc = timestamp_in;
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        en = 1'b0;
        enabled_chan_count = 3'd0;
        data_in_0 = '0; data_in_1 = '0; data_in_2 = '0; data_in_3 = '0;
        #1;
        check("rst_data",  data_out, 64'h0);
        check("rst_valid", {63'h0, data_out_valid}, 64'h0);
        check("rst_sync",  {63'h0, data_out_sync}, 64'h0);
        check("rst_ts",    timestamp_out, 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;

        // N=1: four sets per word
        apply_set(1, 1, 0, t0);
        check("n1_v0", {63'h0, data_out_valid}, 64'h0);
        apply_set(1, 1, 4, tx);
        apply_set(1, 1, 8, tx);
        check("n1_v2", {63'h0, data_out_valid}, 64'h0);
        apply_set(1, 1, 12, tx);
        check("n1_valid", {63'h0, data_out_valid}, 64'h1);
        check("n1_data",  data_out, 64'h000d_0009_0005_0001);
        check("n1_ts",    timestamp_out, t0);
        check("n1_sync",  {63'h0, data_out_sync}, 64'h1);
        apply_set(1, 1, 16, tx);
        apply_set(1, 1, 20, tx);
        apply_set(1, 1, 24, tx);
        apply_set(1, 1, 28, tx);
        check("n1_data2", data_out, 64'h001d_0019_0015_0011);
        check("n1_ts2",   timestamp_out, t0 + 64'd4);
        apply_set(0, 1, 0, tx);

        // N=2: two sets per word
        apply_set(1, 2, 0, t0);
        apply_set(1, 2, 4, tx);
        check("n2_data", data_out, 64'h0006_0005_0002_0001);
        check("n2_ts",   timestamp_out, t0);
        check("n2_sync", {63'h0, data_out_sync}, 64'h1);
        apply_set(1, 2, 8, tx);
        apply_set(1, 2, 12, tx);
        check("n2_data2", data_out, 64'h000e_000d_000a_0009);
        check("n2_ts2",   timestamp_out, t0 + 64'd2);
        apply_set(0, 2, 0, tx);

        // N=4: a word per set, one cycle latency
        apply_set(1, 4, 0, t0);
        check("n4_valid", {63'h0, data_out_valid}, 64'h1);
        check("n4_data",  data_out, 64'h0004_0003_0002_0001);
        check("n4_ts",    timestamp_out, t0);
        apply_set(1, 4, 4, tx);
        check("n4_data2", data_out, 64'h0008_0007_0006_0005);
        check("n4_ts2",   timestamp_out, t0 + 64'd1);
        check("n4_sync2", {63'h0, data_out_sync}, 64'h1);
        apply_set(0, 4, 8, tx);
        check("idle_valid", {63'h0, data_out_valid}, 64'h0);
        check("idle_hold",  data_out, 64'h0008_0007_0006_0005);

        // N=3: carry across words, sync every third word
        apply_set(1, 3, 0, t0);
        check("n3_v0", {63'h0, data_out_valid}, 64'h0);
        apply_set(1, 3, 4, tx);
        check("n3_w0",    data_out, 64'h0005_0003_0002_0001);
        check("n3_ts0",   timestamp_out, t0);
        check("n3_sync0", {63'h0, data_out_sync}, 64'h1);
        apply_set(1, 3, 8, tx);
        check("n3_w1",    data_out, 64'h000a_0009_0007_0006);
        check("n3_ts1",   timestamp_out, t0 + 64'd1);
        check("n3_sync1", {63'h0, data_out_sync}, 64'h0);
        apply_set(1, 3, 12, tx);
        check("n3_w2",    data_out, 64'h000f_000e_000d_000b);
        check("n3_ts2",   timestamp_out, t0 + 64'd2);
        check("n3_sync2", {63'h0, data_out_sync}, 64'h0);
        apply_set(1, 3, 16, t0);
        apply_set(1, 3, 20, tx);
        check("n3_w3",    data_out, 64'h0015_0013_0012_0011);
        check("n3_ts3",   timestamp_out, t0);
        check("n3_sync3", {63'h0, data_out_sync}, 64'h1);
        apply_set(1, 3, 24, tx);
        apply_set(1, 3, 28, tx);

        // N above 4 clamps; N=0 is idle
        apply_set(1, 7, 0, tx);
        check("clamp7", data_out, 64'h0004_0003_0002_0001);
        apply_set(1, 5, 4, tx);
        check("clamp5", data_out, 64'h0008_0007_0006_0005);
        apply_set(1, 0, 8, tx);
        check("n0_valid", {63'h0, data_out_valid}, 64'h0);
        check("n0_hold",  data_out, 64'h0008_0007_0006_0005);
        apply_set(0, 0, 0, tx);

        // Changing N discards the partial word
        apply_set(1, 1, 0, tx);
        apply_set(1, 1, 4, tx);
        apply_set(1, 2, 8, t0);
        check("chg_v", {63'h0, data_out_valid}, 64'h0);
        apply_set(1, 2, 12, tx);
        check("chg_data", data_out, 64'h000e_000d_000a_0009);
        check("chg_ts",   timestamp_out, t0);
        apply_set(0, 2, 0, tx);

        // Reset mid-word
        apply_set(1, 1, 0, tx);
        apply_set(1, 1, 4, tx);
        resetn = 1'b0;
        #1;
        check("mrst_data",  data_out, 64'h0);
        check("mrst_valid", {63'h0, data_out_valid}, 64'h0);
        check("mrst_ts",    timestamp_out, 64'h0);
        en = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        apply_set(1, 1, 100, t0);
        apply_set(1, 1, 104, tx);
        apply_set(1, 1, 108, tx);
        apply_set(1, 1, 112, tx);
        check("mrst_word", data_out, 64'h0071_006d_0069_0065);
        check("mrst_wts",  timestamp_out, t0);
        apply_set(0, 1, 0, tx);

        // Partial word across an en gap
        apply_set(1, 3, 0, t0);
        apply_set(0, 3, 0, tx);
`ifdef PACKER_FLUSH_EN
        check("flush_valid", {63'h0, data_out_valid}, 64'h1);
        check("flush_data",  data_out, 64'h0000_0003_0002_0001);
        check("flush_sync",  {63'h0, data_out_sync}, 64'h1);
        check("flush_ts",    timestamp_out, t0);
`else
        check("gap_valid", {63'h0, data_out_valid}, 64'h0);
        apply_set(1, 3, 4, tx);
        check("gap_valid2", {63'h0, data_out_valid}, 64'h1);
        check("gap_data",   data_out, 64'h0005_0003_0002_0001);
        check("gap_sync",   {63'h0, data_out_sync}, 64'h1);
        check("gap_ts",     timestamp_out, t0);
`endif
        apply_set(0, 3, 0, tx);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
